clock_monitor: RTL and testbench
================================

# clock_monitor

Measures the period of a divided clock (e.g. the 8334-cycle or 512-cycle outputs of the on-chip clock divider) in `clkin` cycles and qualifies it against an expected value. It synchronizes the monitored clock, detects rising edges, reports each measured period, and runs a lock/loss state machine. It sits in the `clkin` domain beside the divider and gates downstream laser/ADC sequencing on `locked`.

## Interface
- `EXP_PERIOD`, 16'd8334: expected period of `mon_in` in `clkin` cycles.
- `TOL`, 16'd8: allowed absolute deviation; a period is good iff |period − EXP_PERIOD| ≤ TOL.
- `LOCK_CNT`, 4: consecutive good periods needed for lock, range 1–15.
- `TIMEOUT`, 16'd16668: cycles without a rising edge before timeout; must be greater than EXP_PERIOD+TOL.
- `clkin` input 1: sole clock, rising edge.
- `ncr` input 1: reset, asynchronous, active-low.
- `mon_in` input 1: monitored clock, treated as asynchronous to `clkin`.
- `period` output 16: last measured period, held until the next measurement.
- `period_valid` output 1: one-cycle pulse when `period` updates.
- `locked` output 1: high in LOCKED.
- `lost` output 1: high in LOST.
- `err_cnt` output 8: saturating count of bad periods plus timeouts.

## Operation
- Input path: 2-flop synchronizer, then previous-sample register. `rise` = sync & ~prev.
- Counter `cnt` (16b): increments every cycle and saturates at 16'hFFFF. On `rise`: `period` ← `cnt`, `cnt` ← 1. This gives period 8334 for a signal toggling every 4167 cycles.
- `period`/`period_valid` update only on rises in MEASURE, LOCKED or LOST. The first rise after SEARCH is a reference edge only.
- Timeout: `cnt` == TIMEOUT with no `rise` in the same cycle. If both happen in the same cycle, `rise` wins and is measured as a normal (bad) period.
- `good_cnt` (4b) counts consecutive good periods.
- States, reset = SEARCH:
  - SEARCH: on `rise` → MEASURE, with `cnt`←1 and `good_cnt`←0.
  - MEASURE:
    - Good period: `good_cnt`+1. When it reaches LOCK_CNT → LOCKED.
    - Bad period: `good_cnt`←0, `err_cnt`+1, stay in MEASURE.
    - Timeout: → SEARCH, `err_cnt`+1.
  - LOCKED: good period → stay. Bad period or timeout → LOST, `err_cnt`+1.
  - LOST: `good_cnt`←0.
    - On `rise`: measure the period (reported, not qualified), → MEASURE.
    - On timeout: stay in LOST and restart `cnt` at 1. `err_cnt` increments once per timeout.
- `err_cnt` saturates at 8'hFF. It is cleared only by reset.
- Reset values: `period`=0, `period_valid`=0, `locked`=0, `lost`=0, `err_cnt`=0, `cnt`=0, synchronizer and previous-sample flops 0, state SEARCH.
- Reset during operation takes effect immediately and clears all state. The first edge after release is a reference edge.

## Timing
- A `mon_in` rise first sampled high at `clkin` edge N gives `rise` in cycle N+2 and `period_valid`/`period` in cycle N+3 (N+5 with deglitch).
- `locked` rises in the same cycle as the `period_valid` of the LOCK_CNT-th good period. It falls in the same cycle as the `period_valid` of the first bad period, or in the cycle after the timeout.
- `lost` asserts when `locked` falls. It deasserts in the cycle after the next `rise` is processed.
- Minimum measurable period: 4 `clkin` cycles. A shorter pulse is a glitch and behaviour is undefined unless deglitch is enabled.

## Configuration
- `CLKMON_DEGLITCH_EN` defined:
  - A 3-stage filter follows the synchronizer. The filtered level changes only after 3 consecutive equal synchronized samples.
  - Adds 2 cycles of latency. Pulses of 2 cycles or less are rejected.
  - The measured period is unchanged for clean input.
- Not defined: the filter is absent and the synchronizer output feeds edge detection directly.

## Test plan
- Default params, `mon_in` toggles every 4167 cycles → first `period_valid` on the 2nd rise, `period`=8334; `locked`=1 on the 5th rise; `err_cnt`=0.
- EXP_PERIOD=512, LOCK_CNT=2, toggle every 256 → `period`=512; `locked` on the 3rd rise.
- Locked, then one period stretched to 8350 → `locked` 0, `lost` 1, `err_cnt`=1. Normal periods resume → MEASURE, and relock after 4 good periods following the resync edge.
- Locked, then `mon_in` held low → after 16668 cycles from the last rise, `lost`=1 and `err_cnt`=1. Still held → `err_cnt`=2 after 16668 more cycles.
- `ncr` pulsed low while locked → all outputs 0 asynchronously. After release the first rise gives no `period_valid`.
- With `CLKMON_DEGLITCH_EN`, a 1-cycle `mon_in` glitch mid-period → no extra `period_valid`, `period` stays 8334, `locked` held.

Source files
------------

// File: rtl/clock_monitor_if.sv
// clock_monitor_if: monitored clock input plus the measurement and lock-status outputs.
// The master modport is the monitor itself; the slave modport is the downstream consumer.
interface clock_monitor_if;
  logic        mon_in;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        lost;
  logic [7:0]  err_cnt;

  modport master (input mon_in, output period, period_valid, locked, lost, err_cnt);
  modport slave  (output mon_in, input period, period_valid, locked, lost, err_cnt);
endinterface

// File: rtl/clock_monitor.sv
// clock_monitor: measures the period of a divided clock in clkin cycles and runs a lock/loss FSM.
// Optional macro CLKMON_DEGLITCH_EN inserts a 3-sample level filter after the synchronizer.
module clock_monitor #(
  parameter logic [15:0] EXP_PERIOD = 16'd8334,
  parameter logic [15:0] TOL        = 16'd8,
  parameter int unsigned LOCK_CNT   = 4,
  parameter logic [15:0] TIMEOUT    = 16'd16668
) (
  input logic             clkin,
  input logic             ncr,
  clock_monitor_if.master mon
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED, LOST} state_t;

  localparam logic [16:0] LO_LIM   = (EXP_PERIOD > TOL) ? ({1'b0, EXP_PERIOD} - {1'b0, TOL}) : 17'd0;
  localparam logic [16:0] HI_LIM   = {1'b0, EXP_PERIOD} + {1'b0, TOL};
  localparam logic [3:0]  LOCK_TGT = LOCK_CNT[3:0];

  state_t      state_reg;
  logic        sync1_reg;
  logic        sync2_reg;
  logic        prev_reg;
  logic        level;
  logic        rise;
  logic        timeout;
  logic        good;
  logic        err_inc;
  logic [15:0] cnt_reg;
  logic [15:0] period_reg;
  logic        period_valid_reg;
  logic        locked_reg;
  logic        lost_reg;
  logic [3:0]  good_cnt_reg;
  logic [3:0]  good_cnt_inc;
  logic [7:0]  err_cnt_reg;

  always_ff @(posedge clkin or negedge ncr) begin
    if (!ncr) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= mon.mon_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= level;
    end
  end

`ifdef CLKMON_DEGLITCH_EN
  logic [1:0] hist_reg;

  always_ff @(posedge clkin or negedge ncr) begin
    if (!ncr) begin
      hist_reg <= 2'b00;
    end else begin
      hist_reg <= {hist_reg[0], sync2_reg};
    end
  end

  // The filtered level only moves once three consecutive synchronized samples agree.
  assign level = (sync2_reg == hist_reg[0] && sync2_reg == hist_reg[1]) ? sync2_reg : prev_reg;
`else
  assign level = sync2_reg;
`endif

  assign rise         = level & ~prev_reg;
  // A rise landing on the timeout cycle wins and is measured as an ordinary period.
  assign timeout      = (state_reg != SEARCH) && (cnt_reg == TIMEOUT) && !rise;
  assign good         = ({1'b0, cnt_reg} >= LO_LIM) && ({1'b0, cnt_reg} <= HI_LIM);
  assign good_cnt_inc = good_cnt_reg + 4'd1;
  assign err_inc      = timeout ||
                        (rise && !good && (state_reg == MEASURE || state_reg == LOCKED));

  always_ff @(posedge clkin or negedge ncr) begin
    if (!ncr) begin
      state_reg        <= SEARCH;
      cnt_reg          <= 16'd0;
      period_reg       <= 16'd0;
      period_valid_reg <= 1'b0;
      locked_reg       <= 1'b0;
      lost_reg         <= 1'b0;
      good_cnt_reg     <= 4'd0;
      err_cnt_reg      <= 8'd0;
    end else begin
      period_valid_reg <= 1'b0;

      // Any timeout restarts the count so a persistent loss keeps reporting once per interval.
      if (rise || timeout) begin
        cnt_reg <= 16'd1;
      end else if (cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end

      if (rise && state_reg != SEARCH) begin
        period_reg       <= cnt_reg;
        period_valid_reg <= 1'b1;
      end

      if (err_inc && err_cnt_reg != 8'hFF) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end

      case (state_reg)
        SEARCH: begin
          if (rise) begin
            state_reg    <= MEASURE;
            good_cnt_reg <= 4'd0;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (good) begin
              good_cnt_reg <= good_cnt_inc;
              if (good_cnt_inc == LOCK_TGT) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end else begin
              good_cnt_reg <= 4'd0;
            end
          end else if (timeout) begin
            state_reg <= SEARCH;
          end
        end
        LOCKED: begin
          if ((rise && !good) || timeout) begin
            state_reg  <= LOST;
            locked_reg <= 1'b0;
            lost_reg   <= 1'b1;
          end
        end
        LOST: begin
          good_cnt_reg <= 4'd0;
          if (rise) begin
            state_reg <= MEASURE;
            lost_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= SEARCH;
        end
      endcase
    end
  end

  assign mon.period       = period_reg;
  assign mon.period_valid = period_valid_reg;
  assign mon.locked       = locked_reg;
  assign mon.lost         = lost_reg;
  assign mon.err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed stimulus with a queue-based scoreboard on period_valid.
// Instance a uses a scaled-down 100-cycle period; instance b uses 512 cycles with LOCK_CNT=2.
module tb_clock_monitor;

  typedef struct {
    int period;
    bit locked;
    bit lost;
    int err;
  } exp_t;

  logic clkin = 1'b0;
  logic ncr   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t got_a;
  exp_t got_b;

  clock_monitor_if bus_a ();
  clock_monitor_if bus_b ();

  clock_monitor #(
    .EXP_PERIOD(16'd100),
    .TOL       (16'd8),
    .LOCK_CNT  (4),
    .TIMEOUT   (16'd200)
  ) u_a (
    .clkin(clkin),
    .ncr  (ncr),
    .mon  (bus_a)
  );

  clock_monitor #(
    .EXP_PERIOD(16'd512),
    .TOL       (16'd8),
    .LOCK_CNT  (2),
    .TIMEOUT   (16'd1024)
  ) u_b (
    .clkin(clkin),
    .ncr  (ncr),
    .mon  (bus_b)
  );

  always #5 clkin = ~clkin;

  function automatic void chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endfunction

  function automatic exp_t mk(int per, bit lk, bit ls, int err);
    exp_t e;
    e.period = per;
    e.locked = lk;
    e.lost   = ls;
    e.err    = err;
    return e;
  endfunction

  // One rise of mon_in followed by hi/lo phases; the expectation is for the period ending at this rise.
  task automatic edge_a(bit v, int per, bit lk, bit ls, int err, int hi, int lo);
    if (v) q_a.push_back(mk(per, lk, ls, err));
    bus_a.mon_in = 1'b1;
    repeat (hi) @(negedge clkin);
    bus_a.mon_in = 1'b0;
    repeat (lo) @(negedge clkin);
  endtask

  task automatic edge_b(bit v, int per, bit lk, bit ls, int err, int hi, int lo);
    if (v) q_b.push_back(mk(per, lk, ls, err));
    bus_b.mon_in = 1'b1;
    repeat (hi) @(negedge clkin);
    bus_b.mon_in = 1'b0;
    repeat (lo) @(negedge clkin);
  endtask

`ifdef CLKMON_DEGLITCH_EN
  // A 100-cycle period with a single-cycle high glitch inside the low phase.
  task automatic glitch_a(int per, bit lk, bit ls, int err);
    q_a.push_back(mk(per, lk, ls, err));
    bus_a.mon_in = 1'b1;
    repeat (50) @(negedge clkin);
    bus_a.mon_in = 1'b0;
    repeat (20) @(negedge clkin);
    bus_a.mon_in = 1'b1;
    @(negedge clkin);
    bus_a.mon_in = 1'b0;
    repeat (29) @(negedge clkin);
  endtask
`endif

  always @(negedge clkin) begin
    if (ncr && bus_a.period_valid) begin
      $display("a valid: period=%0d locked=%0b lost=%0b err=%0d",
               bus_a.period, bus_a.locked, bus_a.lost, bus_a.err_cnt);
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_valid: got period=%0d, want no period_valid", bus_a.period);
      end else begin
        got_a = q_a.pop_front();
        chk("a_period", int'(bus_a.period), got_a.period);
        chk("a_locked", int'(bus_a.locked), int'(got_a.locked));
        chk("a_lost",   int'(bus_a.lost),   int'(got_a.lost));
        chk("a_err",    int'(bus_a.err_cnt), got_a.err);
      end
    end
  end

  always @(negedge clkin) begin
    if (ncr && bus_b.period_valid) begin
      $display("b valid: period=%0d locked=%0b lost=%0b err=%0d",
               bus_b.period, bus_b.locked, bus_b.lost, bus_b.err_cnt);
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_valid: got period=%0d, want no period_valid", bus_b.period);
      end else begin
        got_b = q_b.pop_front();
        chk("b_period", int'(bus_b.period), got_b.period);
        chk("b_locked", int'(bus_b.locked), int'(got_b.locked));
        chk("b_lost",   int'(bus_b.lost),   int'(got_b.lost));
        chk("b_err",    int'(bus_b.err_cnt), got_b.err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.mon_in = 1'b0;
    bus_b.mon_in = 1'b0;
    ncr = 1'b0;
    repeat (3) @(negedge clkin);
    chk("rst_period", int'(bus_a.period), 0);
    chk("rst_valid",  int'(bus_a.period_valid), 0);
    chk("rst_locked", int'(bus_a.locked), 0);
    chk("rst_lost",   int'(bus_a.lost), 0);
    chk("rst_err",    int'(bus_a.err_cnt), 0);
    ncr = 1'b1;
    repeat (2) @(negedge clkin);

    // Instance b: 512-cycle period, lock after two good periods (third rise).
    edge_b(0, 0,   0, 0, 0, 256, 256);
    edge_b(1, 512, 0, 0, 0, 256, 256);
    edge_b(1, 512, 1, 0, 0, 256, 256);
    edge_b(1, 512, 1, 0, 0, 256, 256);

    // Instance a: reference edge, then lock on the fifth rise.
    edge_a(0, 0,   0, 0, 0, 50, 50);
    edge_a(1, 100, 0, 0, 0, 50, 50);
    edge_a(1, 100, 0, 0, 0, 50, 50);
    edge_a(1, 100, 0, 0, 0, 50, 50);
    edge_a(1, 100, 1, 0, 0, 54, 54);
    // Tolerance edges: 108 and 92 are good, 109 is bad.
    edge_a(1, 108, 1, 0, 0, 46, 46);
`ifdef CLKMON_DEGLITCH_EN
    glitch_a(92, 1, 0, 0);
`else
    edge_a(1, 92,  1, 0, 0, 50, 50);
`endif
    edge_a(1, 100, 1, 0, 0, 50, 59);
    edge_a(1, 109, 0, 1, 1, 50, 50);
    // Resync edge reported but not qualified; then a bad period inside MEASURE resets the run.
    edge_a(1, 100, 0, 0, 1, 50, 50);
    edge_a(1, 100, 0, 0, 1, 45, 46);
    edge_a(1, 91,  0, 0, 2, 50, 50);
    edge_a(1, 100, 0, 0, 2, 50, 50);
    edge_a(1, 100, 0, 0, 2, 50, 50);
    edge_a(1, 100, 0, 0, 2, 50, 50);
    edge_a(1, 100, 1, 0, 2, 50, 50);

    // Last rise while locked, then mon_in held low through two timeouts.
    q_a.push_back(mk(100, 1, 0, 2));
    bus_a.mon_in = 1'b1;
    repeat (50) @(negedge clkin);
    bus_a.mon_in = 1'b0;
    repeat (145) @(negedge clkin);
    chk("to_before_locked", int'(bus_a.locked), 1);
    chk("to_before_err",    int'(bus_a.err_cnt), 2);
    repeat (15) @(negedge clkin);
    chk("to1_locked", int'(bus_a.locked), 0);
    chk("to1_lost",   int'(bus_a.lost), 1);
    chk("to1_err",    int'(bus_a.err_cnt), 3);
    repeat (185) @(negedge clkin);
    chk("to2_before_err", int'(bus_a.err_cnt), 3);
    repeat (15) @(negedge clkin);
    chk("to2_err",  int'(bus_a.err_cnt), 4);
    chk("to2_lost", int'(bus_a.lost), 1);
    repeat (10) @(negedge clkin);

    // Rise 20 cycles after the second timeout restarted the count, then relock.
    edge_a(1, 20,  0, 0, 4, 50, 50);
    edge_a(1, 100, 0, 0, 4, 50, 50);
    edge_a(1, 100, 0, 0, 4, 50, 50);
    edge_a(1, 100, 0, 0, 4, 50, 50);
    edge_a(1, 100, 1, 0, 4, 50, 50);
    edge_a(1, 100, 1, 0, 4, 50, 50);

    // Asynchronous reset while locked.
    ncr = 1'b0;
    #1;
    chk("arst_period", int'(bus_a.period), 0);
    chk("arst_valid",  int'(bus_a.period_valid), 0);
    chk("arst_locked", int'(bus_a.locked), 0);
    chk("arst_lost",   int'(bus_a.lost), 0);
    chk("arst_err",    int'(bus_a.err_cnt), 0);
    repeat (3) @(negedge clkin);
    ncr = 1'b1;
    repeat (2) @(negedge clkin);
    edge_a(0, 0,   0, 0, 0, 50, 50);
    edge_a(1, 100, 0, 0, 0, 50, 50);
    edge_a(1, 100, 0, 0, 0, 50, 50);
    repeat (10) @(negedge clkin);

    chk("a_pending", q_a.size(), 0);
    chk("b_pending", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
